// File: rtl/dac_serial_pkg.sv
// Shared types and constants for the multi-channel DAC serializer.
// Holds the FSM encoding, floor values for divider/gap and a mask popcount.
package dac_serial_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SCLK_LO,
    S_SCLK_HI,
    S_GAP,
    S_FINISH
  } state_t;

  localparam int MIN_DIV = 1;
  localparam int MIN_GAP = 1;

  function automatic int popcount(input logic [15:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 16; i++) n += int'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/dac_serial_multi_tick.sv
// Loadable half-period counter for SCLK generation.
// tick is high in the last cycle of every D-cycle half period.
module sclk_tick_gen #(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // reload on frame start or at each half-period boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (load || cnt == '0) cnt <= div - DIV_W'(1);
    else cnt <= cnt - DIV_W'(1);
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/dac_serial_multi.sv
// Multi-channel SYNC/SCLK/DIN DAC serializer, per-channel or daisy framing.
// All pins are driven from registers; inputs are latched on an accepted start.
module dac_serial_multi
  import dac_serial_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int NUM_CH = 8,
  parameter int DIV_W  = 32,
  parameter int GAP_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [NUM_CH*WORD_W-1:0] data,
  input  logic [NUM_CH-1:0]        chan_mask,
  input  logic                     daisy,
  input  logic [DIV_W-1:0]         sclk_div,
  input  logic [GAP_W-1:0]         gap,
  output logic                     busy,
  output logic                     done,
  output logic                     SYNC,
  output logic                     SCLK,
  output logic                     DIN
);

  localparam int TOT   = NUM_CH * WORD_W;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WB_W  = $clog2(WORD_W);
  localparam int BIT_W = $clog2(TOT + 1);
  localparam int IDX_W = $clog2(TOT);

  state_t             state;
  logic [TOT-1:0]     data_lat;
  logic [NUM_CH-1:0]  mask_lat;
  logic               daisy_lat;
  logic [DIV_W-1:0]   d_lat;
  logic [GAP_W-1:0]   gap_lat;
  logic [CH_W-1:0]    ch;
  logic [WB_W-1:0]    wbit;
  logic [BIT_W-1:0]   bits_left;
  logic [GAP_W-1:0]   gap_cnt;

  logic [DIV_W-1:0]   d_in;
  logic [GAP_W-1:0]   g_in;
  logic [CH_W-1:0]    first_up;
  logic [CH_W-1:0]    first_dn;
  logic [CH_W-1:0]    start_ch;
  logic [CH_W-1:0]    next_up;
  logic [CH_W-1:0]    next_dn;
  logic               has_up;
  logic [CH_W-1:0]    adv_ch;
  logic [WB_W-1:0]    adv_bit;
  logic               start_din;
  logic               adv_din;
  logic               gap_din;
  logic [BIT_W-1:0]   daisy_bits;
  logic               tick;
  logic               load;
  logic [DIV_W-1:0]   div_sel;

  function automatic logic [IDX_W-1:0] pos(
    input logic [CH_W-1:0] c,
    input logic [WB_W-1:0] b
  );
    return IDX_W'(int'(c) * WORD_W + int'(b));
  endfunction

  assign d_in = (sclk_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : sclk_div;
  assign g_in = (gap < GAP_W'(MIN_GAP)) ? GAP_W'(MIN_GAP) : gap;

  // channel search: first enabled on start, neighbours of current channel
  always_comb begin
    first_up = '0;
    first_dn = '0;
    next_up  = '0;
    next_dn  = '0;
    has_up   = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (chan_mask[i]) first_up = CH_W'(i);
      if (mask_lat[i] && i > int'(ch)) begin
        next_up = CH_W'(i);
        has_up  = 1'b1;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (chan_mask[i]) first_dn = CH_W'(i);
      if (mask_lat[i] && i < int'(ch)) next_dn = CH_W'(i);
    end
  end

  // next bit pointer; crossing a word boundary only happens in daisy mode
  always_comb begin
    adv_ch  = ch;
    adv_bit = wbit - WB_W'(1);
    if (wbit == '0) begin
      adv_ch  = next_dn;
      adv_bit = WB_W'(WORD_W - 1);
    end
  end

  assign start_ch   = daisy ? first_dn : first_up;
  assign start_din  = data[pos(start_ch, WB_W'(WORD_W - 1))];
  assign adv_din    = data_lat[pos(adv_ch, adv_bit)];
  assign gap_din    = data_lat[pos(next_up, WB_W'(WORD_W - 1))];
  assign daisy_bits = BIT_W'(popcount(16'(chan_mask)) * WORD_W);

  assign load = (state == S_IDLE && start && chan_mask != '0) ||
                (state == S_GAP && gap_cnt == '0);
  assign div_sel = (state == S_IDLE) ? d_in : d_lat;

  sclk_tick_gen #(
    .DIV_W(DIV_W)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .div  (div_sel),
    .tick (tick)
  );

  // frame sequencer with registered pin outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      SYNC      <= 1'b1;
      SCLK      <= 1'b1;
      DIN       <= 1'b0;
      data_lat  <= '0;
      mask_lat  <= '0;
      daisy_lat <= 1'b0;
      d_lat     <= DIV_W'(MIN_DIV);
      gap_lat   <= GAP_W'(MIN_GAP);
      ch        <= '0;
      wbit      <= '0;
      bits_left <= '0;
      gap_cnt   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          SYNC <= 1'b1;
          SCLK <= 1'b1;
          DIN  <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            data_lat  <= data;
            mask_lat  <= chan_mask;
            daisy_lat <= daisy;
            d_lat     <= d_in;
            gap_lat   <= g_in;
            if (chan_mask == '0) begin
              done <= 1'b1;
            end else begin
              state     <= S_SETUP;
              busy      <= 1'b1;
              SYNC      <= 1'b0;
              ch        <= start_ch;
              wbit      <= WB_W'(WORD_W - 1);
              bits_left <= daisy ? daisy_bits : BIT_W'(WORD_W);
              DIN       <= start_din;
            end
          end
        end
        S_SETUP: begin
          if (tick) begin
            state <= S_SCLK_LO;
            SCLK  <= 1'b0;
          end
        end
        S_SCLK_LO: begin
          if (tick) begin
            state <= S_SCLK_HI;
            SCLK  <= 1'b1;
            if (bits_left > BIT_W'(1)) begin
              ch   <= adv_ch;
              wbit <= adv_bit;
              DIN  <= adv_din;
            end
          end
        end
        S_SCLK_HI: begin
          if (tick) begin
            if (bits_left > BIT_W'(1)) begin
              bits_left <= bits_left - BIT_W'(1);
              state     <= S_SCLK_LO;
              SCLK      <= 1'b0;
            end else begin
              SYNC <= 1'b1;
              if (!daisy_lat && has_up) begin
                state   <= S_GAP;
                gap_cnt <= gap_lat - GAP_W'(1);
              end else begin
                state <= S_FINISH;
                done  <= 1'b1;
              end
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            state     <= S_SETUP;
            SYNC      <= 1'b0;
            ch        <= next_up;
            wbit      <= WB_W'(WORD_W - 1);
            bits_left <= BIT_W'(WORD_W);
            DIN       <= gap_din;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          DIN   <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_serial_multi.sv
// Scoreboard bench for dac_serial_multi: driver queues expected frames,
// a pin monitor rebuilds frames from SYNC/SCLK/DIN and compares.
module tb_dac_serial_multi;

  localparam int WW = 16;
  localparam int NC = 4;
  localparam int DW = 32;
  localparam int GW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [NC*WW-1:0] data = '0;
  logic [NC-1:0]   chan_mask = '0;
  logic            daisy = 1'b0;
  logic [DW-1:0]   sclk_div = '0;
  logic [GW-1:0]   gap = '0;
  logic            busy, done, SYNC, SCLK, DIN;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] bits;
    int          nbits;
    int          low;
    int          gapc;
  } frame_t;

  typedef struct {
    int cyc;
    bit busy;
  } done_t;

  frame_t exp_frames[$];
  done_t  exp_done[$];

  dac_serial_multi #(
    .WORD_W(WW),
    .NUM_CH(NC),
    .DIV_W (DW),
    .GAP_W (GW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .data     (data),
    .chan_mask(chan_mask),
    .daisy    (daisy),
    .sclk_div (sclk_div),
    .gap      (gap),
    .busy     (busy),
    .done     (done),
    .SYNC     (SYNC),
    .SCLK     (SCLK),
    .DIN      (DIN)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, got, want, cyc);
    end
  endtask

  // pin monitor
  logic        sync_p = 1'b1;
  logic        sclk_p = 1'b1;
  logic        din_p = 1'b0;
  int          low_cnt = 0;
  int          hi_cnt = 0;
  int          nfall = 0;
  int          mgap = -1;
  bit          inx = 1'b0;
  logic [63:0] got_bits = '0;

  always @(negedge clk) begin
    frame_t f;
    done_t  d;
    if (!rst_n) begin
      sync_p = 1'b1; sclk_p = 1'b1; din_p = 1'b0;
      low_cnt = 0; hi_cnt = 0; nfall = 0; mgap = -1;
      inx = 1'b0; got_bits = '0;
    end else begin
      if (done) begin
        if (exp_done.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          d = exp_done.pop_front();
          chk("done_cycle", cyc, d.cyc);
          chk("done_busy", busy, d.busy);
        end
        inx = 1'b0;
      end
      if (!SYNC) begin
        if (sync_p) begin
          mgap = inx ? hi_cnt : -1;
          low_cnt = 0; nfall = 0; got_bits = '0; inx = 1'b0;
        end
        low_cnt++;
        chk("busy_in_frame", busy, 1);
        if (sclk_p && !SCLK) begin
          nfall++;
          got_bits = {got_bits[62:0], DIN};
          chk("din_at_fall", DIN, din_p);
        end
        if (!sclk_p && !SCLK) chk("din_stable_low", DIN, din_p);
      end else begin
        if (!sync_p) begin
          if (exp_frames.size() == 0) begin
            chk("spurious_frame", 1, 0);
          end else begin
            f = exp_frames.pop_front();
            chk("frame_bits", got_bits, f.bits);
            chk("frame_falls", nfall, f.nbits);
            chk("frame_low", low_cnt, f.low);
            chk("frame_gap", mgap, f.gapc);
          end
          hi_cnt = 1;
          inx = !done;
        end else if (inx) begin
          hi_cnt++;
        end
      end
      sync_p = SYNC; sclk_p = SCLK; din_p = DIN;
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 2000 && busy; i++) @(negedge clk);
  endtask

  task automatic scramble();
    data      = {$urandom, $urandom};
    chan_mask = NC'($urandom);
    daisy     = 1'($urandom);
    sclk_div  = $urandom_range(0, 7);
    gap       = GW'($urandom_range(0, 7));
  endtask

  task automatic run(input logic [63:0] d, input logic [NC-1:0] m,
                     input bit dz, input int div, input int g,
                     input bit poke);
    int de, ge, t0, tot, nfr, lim;
    logic [63:0] fb;
    int nb;
    frame_t f;
    done_t  dn;
    de = (div < 1) ? 1 : div;
    ge = (g < 1) ? 1 : g;
    wait_idle();
    data = d; chan_mask = m; daisy = dz;
    sclk_div = DW'(div); gap = GW'(g);
    start = 1'b1;
    t0 = cyc;
    tot = 0; nfr = 0;
    if (dz) begin
      fb = '0; nb = 0;
      for (int k = NC - 1; k >= 0; k--)
        if (m[k]) begin
          fb = (fb << WW) | 64'(d[k*WW +: WW]);
          nb += WW;
        end
      if (nb > 0) begin
        f = '{bits: fb, nbits: nb, low: de * (2 * nb + 1), gapc: -1};
        exp_frames.push_back(f);
        tot = f.low;
      end
    end else begin
      for (int k = 0; k < NC; k++)
        if (m[k]) begin
          f = '{bits: 64'(d[k*WW +: WW]), nbits: WW,
                low: de * (2 * WW + 1), gapc: (nfr > 0) ? ge : -1};
          exp_frames.push_back(f);
          tot += f.low + ((nfr > 0) ? ge : 0);
          nfr++;
        end
    end
    dn = '{cyc: t0 + 1 + tot, busy: (m != '0)};
    exp_done.push_back(dn);
    @(negedge clk);
    start = 1'b0;
    if (m == '0) begin
      chk("mask0_busy", busy, 0);
      chk("mask0_sync", SYNC, 1);
    end else begin
      chk("busy_at_1", busy, 1);
      chk("sync_at_1", SYNC, 0);
    end
    scramble();
    if (poke && m != '0) begin
      repeat (5) @(negedge clk);
      start = 1'b1;
      chan_mask = '1;
      daisy = ~dz;
      sclk_div = 3;
      @(negedge clk);
      start = 1'b0;
    end
    lim = tot + 50;
    for (int i = 0; i < lim && exp_done.size() != 0; i++) @(negedge clk);
    if (exp_done.size() != 0) begin
      chk("done_timeout", 1, 0);
      exp_done.delete();
    end
    chk("frames_left", exp_frames.size(), 0);
    exp_frames.delete();
  endtask

  initial begin
    logic [63:0] rd;
    repeat (3) @(negedge clk);
    chk("rst_sync", SYNC, 1);
    chk("rst_sclk", SCLK, 1);
    chk("rst_din", DIN, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run(64'h0000_0000_0000_8005, 4'b0001, 1'b0, 16, 3, 1'b0);
    rd = 64'hA5C3_1234_0F0F_BEEF;
    run(rd, 4'b1010, 1'b0, 2, 5, 1'b0);
    run(rd, 4'b1010, 1'b1, 2, 5, 1'b0);
    run(rd, 4'b0000, 1'b0, 2, 5, 1'b0);
    run({$urandom, $urandom}, 4'b1111, 1'b0, 0, 0, 1'b1);
    run({$urandom, $urandom}, 4'b1011, 1'b1, 0, 0, 1'b1);

    // mid-frame reset around bit 7
    wait_idle();
    data = {$urandom, $urandom}; chan_mask = 4'b0001; daisy = 1'b0;
    sclk_div = 2; gap = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2 + 7 * 4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_sync", SYNC, 1);
    chk("midrst_sclk", SCLK, 1);
    chk("midrst_din", DIN, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    exp_frames.delete();
    exp_done.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run({$urandom, $urandom}, 4'b0110, 1'b0, 1, 2, 1'b0);

    for (int n = 0; n < 24; n++)
      run({$urandom, $urandom}, NC'($urandom), 1'($urandom),
          $urandom_range(0, 3), $urandom_range(0, 4),
          1'($urandom_range(0, 1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_serial_multi.md
# dac_serial_multi

Parametrised multi-channel successor to the single-word 16-bit DAC serializer. Latches a vector of `NUM_CH` words of `WORD_W` bits and shifts the enabled channels out on a SYNC/SCLK/DIN three-wire interface. Two framing modes are supported: one SYNC frame per channel (independent DACs on a shared bus) and one SYNC frame for all channels (daisy-chained DACs). Sits between the DAC register bank and the board DAC pins.

## Interface
- `WORD_W`, 16, bits per channel word (2..32)
- `NUM_CH`, 8, number of channels (1..16)
- `DIV_W`, 32, width of `sclk_div`
- `GAP_W`, 8, width of `gap`

- `clk` in 1 — system clock; single clock domain
- `rst_n` in 1 — asynchronous, active-low reset
- `start` in 1 — one-cycle request; sampled only when `busy`=0
- `data` in NUM_CH*WORD_W — channel k occupies bits [k*WORD_W +: WORD_W]
- `chan_mask` in NUM_CH — 1 = channel k is sent
- `daisy` in 1 — 0 = frame per channel, 1 = single frame
- `sclk_div` in DIV_W — SCLK half-period D in clk cycles; 0 is treated as 1
- `gap` in GAP_W — SYNC-high cycles between frames; 0 is treated as 1
- `busy` out 1 — transfer in progress
- `done` out 1 — one-cycle pulse at end of transfer
- `SYNC` out 1 — active-low frame select
- `SCLK` out 1 — serial clock, idles high
- `DIN` out 1 — serial data, MSB first

## Operation
- Reset (asynchronous, immediate, including mid-frame): SYNC=1, SCLK=1, DIN=0, busy=0, done=0, FSM=IDLE.
- `start` in IDLE latches `data`, `chan_mask`, `daisy`, D and `gap`. Changing the inputs afterwards has no effect. `start` while busy is ignored.
- `chan_mask`=0: no SYNC activity; done pulses the cycle after start; busy stays 0.
- Order:
  - Per-channel mode: enabled channels in ascending index.
  - Daisy mode: enabled channels, highest index shifted first.
  - Disabled channels are skipped entirely.
- FSM states: IDLE → SETUP → SCLK_LO ⇄ SCLK_HI → (GAP → SETUP | FINISH) → IDLE.
  - SETUP: SYNC=0, SCLK=1, DIN=first bit; lasts D cycles.
  - SCLK_LO: SCLK=0, DIN held stable; the DAC samples on the falling edge. Lasts D cycles.
  - SCLK_HI: SCLK=1. DIN updates to the next bit on entry, or holds on the last bit. Lasts D cycles.
  - After the last bit of a frame, SCLK_HI completes, then SYNC=1. Daisy mode frame length = (popcount(mask)·WORD_W) bits.
  - GAP: SYNC=1, SCLK=1 for max(gap,1) cycles, then SETUP for the next channel (per-channel mode only).
  - FINISH: first cycle with SYNC=1 after the final frame; done=1, busy=1. Next cycle returns to IDLE with busy=0.
- DIN returns to 0 in IDLE.
- Counters:
  - Divider counter: DIV_W bits.
  - Bit counter: ≥ clog2(NUM_CH·WORD_W+1) bits.
  - Channel index: clog2(NUM_CH) bits; no wrap past the last enabled channel.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- start sampled at cycle 0 → busy=1 and SYNC=0 at cycle 1.
- SYNC low per frame: D·(2·B+1) cycles, where B = bits in the frame.
- Per-channel mode total: n frames + (n−1) gaps + 1 FINISH cycle.
- Falling SCLK edges per frame = B exactly. SCLK high-phase and low-phase each = D cycles.
- DIN changes only while SCLK=1; it never changes in the same cycle SCLK falls.
- Minimum back-to-back: a new start is accepted in the cycle after done.

## Structure
- Package `dac_serial_pkg`:
  - FSM state enum
  - `MIN_DIV`=1 and `MIN_GAP`=1 constants
  - function `popcount` for the mask
- Sub-module `sclk_tick_gen`: loadable D-cycle down-counter. Emits a one-cycle tick at each half-period boundary. Reset by the FSM on SETUP entry.
- Top level holds: FSM, latched shift vector (NUM_CH·WORD_W), mask and channel index.

## Test plan
- NUM_CH=1, WORD_W=16, D=16, data=16'h8005, start at cycle 0 → SYNC low cycles 1..528; 16 SCLK falls; DIN sampled at falls = 1000_0000_0000_0101; done at cycle 529.
- NUM_CH=4, mask=4'b1010, daisy=0, gap=5, D=2 → two frames: ch1 then ch3; SYNC high exactly 5 cycles between them; each frame 66 cycles low.
- Same data with daisy=1 → single 32-bit frame; ch3 bits first, then ch1; one done pulse.
- mask=0 → done at cycle 1; SYNC/SCLK never toggle; busy stays 0.
- sclk_div=0, gap=0 → behaves as D=1, gap=1 (SCLK = clk/2). Second start issued mid-frame → ignored; bit count unchanged.
- rst_n dropped mid-frame (bit 7) → same cycle SYNC=1, SCLK=1, DIN=0, busy=0; after release, a fresh start completes normally.
